// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the CDB arbiter slice: tag/data widths, the NULL tag,
// enable levels and a width helper for source indices.
package cdb_arbiter_pkg;

   localparam int ROB_WIDTH         = 4;
   localparam int INSTRUCTION_WIDTH = 32;
   localparam int NULL_TAG          = 0;

   localparam logic ENABLE  = 1'b1;
   localparam logic DISABLE = 1'b0;

   // Width of a source index; never below one bit so a single source still has a port.
   function automatic int src_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cdb_arbiter_src_fifo.sv
// Per-source result FIFO: power-of-two depth, naturally wrapping pointers,
// occupancy count one bit wider than the pointers, synchronous flush.
module cdb_src_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 36
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;

   // Pointer and occupancy bookkeeping; flush empties the queue outright.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) tail <= tail + PTR_W'(1);
         if (pop)  head <= head + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage write; contents need no reset because count gates visibility.
   always_ff @(posedge clk) begin
      if (push && !flush) mem[tail] <= din;
   end

   // Head entry is always presented for the arbiter to pick up.
   always_comb begin
      dout = mem[head];
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-source FIFOs feeding a round-robin scanner
// that broadcasts one (tag, value) result per enabled cycle.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int N_SRC      = 2,
   parameter int FIFO_DEPTH = 2,
   parameter int ROB_W      = ROB_WIDTH,
   parameter int DATA_W     = INSTRUCTION_WIDTH
) (
   input  logic                          clk_in,
   input  logic                          rst_in,
   input  logic                          rdy_in,
   input  logic                          rob_flush_in,
   input  logic [N_SRC-1:0]              src_valid_in,
   input  logic [N_SRC*ROB_W-1:0]        src_dest_in,
   input  logic [N_SRC*DATA_W-1:0]       src_value_in,
   output logic [N_SRC-1:0]              src_ready_out,
   output logic                          cdb_en_out,
   output logic [ROB_W-1:0]              cdb_dest_out,
   output logic [DATA_W-1:0]             cdb_value_out,
   output logic [src_width(N_SRC)-1:0]   cdb_src_out
);

   localparam int SRC_W = src_width(N_SRC);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int ENT_W = ROB_W + DATA_W;

   logic [CNT_W-1:0] cnt       [N_SRC];
   logic [ENT_W-1:0] head_data [N_SRC];
   logic [N_SRC-1:0] push;
   logic [N_SRC-1:0] pop;
   logic [N_SRC-1:0] nonempty;

   logic             live;
   logic             flush_en;
   logic [SRC_W-1:0] rr_ptr;
   logic [SRC_W-1:0] rr_next;
   logic [SRC_W-1:0] win;
   logic [SRC_W:0]   cand;
   logic             found;
   logic [ENT_W-1:0] win_entry;

   // Accept side: ready uses the registered count only, NULL tags are swallowed.
   always_comb begin
      live     = rdy_in && !rob_flush_in;
      flush_en = rdy_in && rob_flush_in;
      src_ready_out = '0;
      push          = '0;
      nonempty      = '0;
      for (int unsigned i = 0; i < N_SRC; i++) begin
         nonempty[i]      = (cnt[i] != '0);
         src_ready_out[i] = live && (cnt[i] < CNT_W'(FIFO_DEPTH));
         push[i]          = src_valid_in[i] && src_ready_out[i] &&
                            (src_dest_in[i*ROB_W +: ROB_W] != ROB_W'(NULL_TAG));
      end
   end

   // Round-robin scan from rr_ptr upward, wrapping at N_SRC; first non-empty wins.
   always_comb begin
      found = 1'b0;
      win   = '0;
      cand  = '0;
      for (int unsigned k = 0; k < N_SRC; k++) begin
         cand = {1'b0, rr_ptr} + (SRC_W+1)'(k);
         if (cand >= (SRC_W+1)'(N_SRC)) cand = cand - (SRC_W+1)'(N_SRC);
         if (!found && nonempty[cand[SRC_W-1:0]]) begin
            found = 1'b1;
            win   = cand[SRC_W-1:0];
         end
      end
      rr_next   = (win == SRC_W'(N_SRC - 1)) ? '0 : win + SRC_W'(1);
      win_entry = head_data[win];
   end

   // Pop strobes: only the winner drains, and only in a live cycle.
   always_comb begin
      pop = '0;
      for (int unsigned i = 0; i < N_SRC; i++) begin
         pop[i] = live && found && (win == SRC_W'(i));
      end
   end

   for (genvar g = 0; g < N_SRC; g++) begin : g_src
      cdb_src_fifo #(
         .DEPTH (FIFO_DEPTH),
         .WIDTH (ENT_W)
      ) u_fifo (
         .clk   (clk_in),
         .rst_n (rst_in),
         .push  (push[g]),
         .pop   (pop[g]),
         .flush (flush_en),
         .din   ({src_dest_in[g*ROB_W +: ROB_W], src_value_in[g*DATA_W +: DATA_W]}),
         .dout  (head_data[g]),
         .count (cnt[g])
      );
   end

   // Broadcast registers and rr_ptr; a stall freezes everything, including cdb_en_out.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         rr_ptr        <= '0;
         cdb_en_out    <= DISABLE;
         cdb_dest_out  <= '0;
         cdb_value_out <= '0;
         cdb_src_out   <= '0;
      end else if (rdy_in) begin
         if (rob_flush_in) begin
            rr_ptr     <= '0;
            cdb_en_out <= DISABLE;
         end else if (found) begin
            rr_ptr        <= rr_next;
            cdb_en_out    <= ENABLE;
            cdb_dest_out  <= win_entry[ENT_W-1 -: ROB_W];
            cdb_value_out <= win_entry[DATA_W-1:0];
            cdb_src_out   <= win;
         end else begin
            cdb_en_out <= DISABLE;
         end
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed-vector bench for cdb_arbiter: a table of per-cycle stimulus with
// hand-computed ready/broadcast expectations, plus an async-reset sequence.
module tb_cdb_arbiter;

   logic        clk_in;
   logic        rst_in;
   logic        rdy_in;
   logic        rob_flush_in;
   logic [1:0]  src_valid_in;
   logic [7:0]  src_dest_in;
   logic [63:0] src_value_in;
   logic [1:0]  src_ready_out;
   logic        cdb_en_out;
   logic [3:0]  cdb_dest_out;
   logic [31:0] cdb_value_out;
   logic [0:0]  cdb_src_out;

   int n_vec = 0;
   int n_bad = 0;

   typedef struct {
      logic        rst;
      logic        rdy;
      logic        flush;
      logic [1:0]  vld;
      logic [3:0]  d0;
      logic [31:0] v0;
      logic [3:0]  d1;
      logic [31:0] v1;
      logic [1:0]  ready;
      logic        en;
      logic [3:0]  dest;
      logic [31:0] val;
      logic        src;
   } vec_t;

   vec_t tbl[$];

   cdb_arbiter #(
      .N_SRC      (2),
      .FIFO_DEPTH (2),
      .ROB_W      (4),
      .DATA_W     (32)
   ) dut (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .rdy_in        (rdy_in),
      .rob_flush_in  (rob_flush_in),
      .src_valid_in  (src_valid_in),
      .src_dest_in   (src_dest_in),
      .src_value_in  (src_value_in),
      .src_ready_out (src_ready_out),
      .cdb_en_out    (cdb_en_out),
      .cdb_dest_out  (cdb_dest_out),
      .cdb_value_out (cdb_value_out),
      .cdb_src_out   (cdb_src_out)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   function automatic vec_t mkv(input logic r, input logic rdy, input logic fl,
                                input logic [1:0] vld,
                                input logic [3:0] d0, input logic [31:0] v0,
                                input logic [3:0] d1, input logic [31:0] v1,
                                input logic [1:0] er, input logic ee,
                                input logic [3:0] ed, input logic [31:0] ev,
                                input logic es);
      vec_t t;
      t.rst = r;   t.rdy = rdy; t.flush = fl; t.vld = vld;
      t.d0 = d0;   t.v0 = v0;   t.d1 = d1;    t.v1 = v1;
      t.ready = er; t.en = ee;  t.dest = ed;  t.val = ev; t.src = es;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic drive_idle();
      rob_flush_in = 1'b0;
      src_valid_in = '0;
      src_dest_in  = '0;
      src_value_in = '0;
   endtask

   task automatic pulse_reset();
      @(negedge clk_in);
      drive_idle();
      rdy_in = 1'b1;
      rst_in = 1'b0;
      #2;
      rst_in = 1'b1;
      #1;
   endtask

   // Drive one cycle of stimulus, check ready mid-cycle, then the registered outputs after the edge.
   task automatic apply(input vec_t t, input string tag);
      rdy_in       = t.rdy;
      rob_flush_in = t.flush;
      src_valid_in = t.vld;
      src_dest_in  = {t.d1, t.d0};
      src_value_in = {t.v1, t.v0};
      #1;
      chk({tag, " ready"}, 32'(src_ready_out), 32'(t.ready));
      @(posedge clk_in);
      #1;
      chk({tag, " en"}, 32'(cdb_en_out), 32'(t.en));
      if (t.en) begin
         chk({tag, " dest"},  32'(cdb_dest_out), 32'(t.dest));
         chk({tag, " value"}, cdb_value_out,     t.val);
         chk({tag, " src"},   32'(cdb_src_out),  32'(t.src));
      end
      n_vec++;
   endtask

   initial begin
      rst_in = 1'b0;
      rdy_in = 1'b1;
      drive_idle();

      // Single ALU result
      tbl.push_back(mkv(0,1,0,2'b01, 3,32'hDEADBEEF, 0,32'h0,        2'b11,0, 0,32'h0,0));
      tbl.push_back(mkv(0,1,0,2'b00, 0,32'h0,        0,32'h0,        2'b11,1, 3,32'hDEADBEEF,0));
      tbl.push_back(mkv(0,1,0,2'b00, 0,32'h0,        0,32'h0,        2'b11,0, 0,32'h0,0));
      // Both sources streaming from reset: order 1,9,2,10,3,11
      tbl.push_back(mkv(1,1,0,2'b11, 1,32'h11111111, 9,32'h99999999, 2'b11,0, 0,32'h0,0));
      tbl.push_back(mkv(0,1,0,2'b11, 2,32'h22222222,10,32'hAAAAAAAA, 2'b11,1, 1,32'h11111111,0));
      tbl.push_back(mkv(0,1,0,2'b11, 3,32'h33333333,11,32'hBBBBBBBB, 2'b01,1, 9,32'h99999999,1));
      tbl.push_back(mkv(0,1,0,2'b10, 0,32'h0,       11,32'hBBBBBBBB, 2'b10,1, 2,32'h22222222,0));
      tbl.push_back(mkv(0,1,0,2'b00, 0,32'h0,        0,32'h0,        2'b01,1,10,32'hAAAAAAAA,1));
      tbl.push_back(mkv(0,1,0,2'b00, 0,32'h0,        0,32'h0,        2'b11,1, 3,32'h33333333,0));
      tbl.push_back(mkv(0,1,0,2'b00, 0,32'h0,        0,32'h0,        2'b11,1,11,32'hBBBBBBBB,1));
      tbl.push_back(mkv(0,1,0,2'b00, 0,32'h0,        0,32'h0,        2'b11,0, 0,32'h0,0));
      // Fill load-buffer FIFO; a pop does not give ready back in the same cycle
      tbl.push_back(mkv(0,1,0,2'b11, 4,32'h44444444, 5,32'h55555555, 2'b11,0, 0,32'h0,0));
      tbl.push_back(mkv(0,1,0,2'b10, 0,32'h0,        6,32'h66666666, 2'b11,1, 4,32'h44444444,0));
      tbl.push_back(mkv(0,1,0,2'b10, 0,32'h0,        7,32'h77777777, 2'b01,1, 5,32'h55555555,1));
      tbl.push_back(mkv(0,1,0,2'b10, 0,32'h0,        7,32'h77777777, 2'b11,1, 6,32'h66666666,1));
      tbl.push_back(mkv(0,1,0,2'b00, 0,32'h0,        0,32'h0,        2'b11,1, 7,32'h77777777,1));
      tbl.push_back(mkv(0,1,0,2'b00, 0,32'h0,        0,32'h0,        2'b11,0, 0,32'h0,0));
      // Flush with queued data and a new valid in the flush cycle
      tbl.push_back(mkv(0,1,0,2'b11,12,32'hCCCCCCCC,13,32'hDDDDDDDD, 2'b11,0, 0,32'h0,0));
      tbl.push_back(mkv(0,1,0,2'b11,14,32'hEEEEEEEE,15,32'hFFFFFFFF, 2'b11,1,12,32'hCCCCCCCC,0));
      tbl.push_back(mkv(0,1,1,2'b11, 8,32'h88888888, 9,32'h99999999, 2'b00,0, 0,32'h0,0));
      tbl.push_back(mkv(0,1,0,2'b00, 0,32'h0,        0,32'h0,        2'b11,0, 0,32'h0,0));
      tbl.push_back(mkv(0,1,0,2'b00, 0,32'h0,        0,32'h0,        2'b11,0, 0,32'h0,0));
      // Stall for 3 cycles with tag 5 on the bus, then resume from saved rr_ptr
      tbl.push_back(mkv(0,1,0,2'b11, 5,32'h55555555, 6,32'h66666666, 2'b11,0, 0,32'h0,0));
      tbl.push_back(mkv(0,1,0,2'b01, 7,32'h77777777, 0,32'h0,        2'b11,1, 5,32'h55555555,0));
      tbl.push_back(mkv(0,0,0,2'b11,10,32'hAAAAAAAA,11,32'hBBBBBBBB, 2'b00,1, 5,32'h55555555,0));
      tbl.push_back(mkv(0,0,0,2'b11,10,32'hAAAAAAAA,11,32'hBBBBBBBB, 2'b00,1, 5,32'h55555555,0));
      tbl.push_back(mkv(0,0,0,2'b11,10,32'hAAAAAAAA,11,32'hBBBBBBBB, 2'b00,1, 5,32'h55555555,0));
      tbl.push_back(mkv(0,1,0,2'b00, 0,32'h0,        0,32'h0,        2'b11,1, 6,32'h66666666,1));
      tbl.push_back(mkv(0,1,0,2'b00, 0,32'h0,        0,32'h0,        2'b11,1, 7,32'h77777777,0));
      tbl.push_back(mkv(0,1,0,2'b00, 0,32'h0,        0,32'h0,        2'b11,0, 0,32'h0,0));

      // Reset state
      #2;
      chk("reset en",    32'(cdb_en_out),   32'h0);
      chk("reset dest",  32'(cdb_dest_out), 32'h0);
      chk("reset value", cdb_value_out,     32'h0);
      chk("reset src",   32'(cdb_src_out),  32'h0);
      n_vec++;
      @(negedge clk_in);
      rst_in = 1'b1;
      #1;

      for (int i = 0; i < tbl.size(); i++) begin
         if (tbl[i].rst) pulse_reset();
         apply(tbl[i], $sformatf("row%0d", i));
      end

      // Asynchronous reset between edges with data queued (rr_ptr is 1 here)
      apply(mkv(0,1,0,2'b11, 3,32'h33333333, 4,32'h44444444, 2'b11,0, 0,32'h0,0), "async_a");
      apply(mkv(0,1,0,2'b00, 0,32'h0,        0,32'h0,        2'b11,1, 4,32'h44444444,1), "async_b");
      #3;
      rst_in = 1'b0;
      #1;
      chk("async en",    32'(cdb_en_out),    32'h0);
      chk("async dest",  32'(cdb_dest_out),  32'h0);
      chk("async value", cdb_value_out,      32'h0);
      chk("async src",   32'(cdb_src_out),   32'h0);
      chk("async ready", 32'(src_ready_out), 32'h3);
      n_vec++;
      #1;
      rst_in = 1'b1;
      apply(mkv(0,1,0,2'b00, 0,32'h0, 0,32'h0, 2'b11,0, 0,32'h0,0), "post_rst_a");
      apply(mkv(0,1,0,2'b00, 0,32'h0, 0,32'h0, 2'b11,0, 0,32'h0,0), "post_rst_b");
      // NULL tag is accepted but never broadcast
      apply(mkv(0,1,0,2'b01, 0,32'h12345678, 0,32'h0, 2'b11,0, 0,32'h0,0), "null_a");
      apply(mkv(0,1,0,2'b00, 0,32'h0, 0,32'h0, 2'b11,0, 0,32'h0,0), "null_b");
      apply(mkv(0,1,0,2'b00, 0,32'h0, 0,32'h0, 2'b11,0, 0,32'h0,0), "null_c");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
